// File: rtl/pcu_hs.sv
// Program-counter unit: hands each PC to the fetch unit over valid/ready, then
// holds until the execute unit commits that instruction and selects the next PC.
module pcu_hs #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(32'h8000_0000),
    parameter int unsigned      IALIGN       = 32,
    parameter int unsigned      CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pc_valid,
    input  logic             pc_ready,
    output logic [XLEN-1:0]  pc,
    input  logic             commit_valid,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic             jal_en,
    input  logic             jalr_en,
    input  logic             branch_en,
    input  logic             branch_taken,
    input  logic             ecall_en,
    input  logic             mret_en,
    input  logic [XLEN-1:0]  mtvec,
    input  logic [XLEN-1:0]  mepc,
    output logic             misalign_trap,
    output logic [XLEN-1:0]  misalign_addr,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 32) ? ~XLEN'(3) : ~XLEN'(1);
    localparam logic [XLEN-1:0] INSN_STEP  = (IALIGN == 32) ? XLEN'(4) : XLEN'(2);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_misalign_addr;
    logic             r_misalign_trap;
    logic [CNT_W-1:0] r_issue_cnt;

    logic             w_fire;
    logic             w_commit;
    logic             w_is_jump;
    logic             w_use_target;
    logic             w_misalign;
    logic [XLEN-1:0]  w_jal_tgt;
    logic [XLEN-1:0]  w_jalr_tgt;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_next_pc;

    function automatic logic [XLEN-1:0] f_align(input logic [XLEN-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    // Only the bit that the active alignment cares about is inspected.
    function automatic logic f_misaligned(input logic [XLEN-1:0] addr);
        return (IALIGN == 32) ? addr[1] : addr[0];
    endfunction

    assign w_fire     = (r_state == S_ISSUE) && pc_ready;
    assign w_commit   = (r_state == S_WAIT) && commit_valid;
    assign w_is_jump  = jal_en || (branch_en && branch_taken);
    assign w_jal_tgt  = r_pc + imm;
    assign w_jalr_tgt = (rs1_data + imm) & ~XLEN'(1);

    always_comb begin
        w_next_pc    = r_pc + INSN_STEP;
        w_target     = '0;
        w_use_target = 1'b0;
        w_misalign   = 1'b0;
        if (ecall_en) begin
            w_next_pc = f_align(mtvec);
        end else if (mret_en) begin
            w_next_pc = f_align(mepc);
        end else if (w_is_jump) begin
            w_target     = w_jal_tgt;
            w_use_target = 1'b1;
        end else if (jalr_en) begin
            w_target     = w_jalr_tgt;
            w_use_target = 1'b1;
        end
        // Computed targets that break alignment are redirected to the trap vector.
        if (w_use_target) begin
            if (f_misaligned(w_target)) begin
                w_next_pc  = f_align(mtvec);
                w_misalign = 1'b1;
            end else begin
                w_next_pc  = w_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_ISSUE;
            S_ISSUE: if (pc_ready)     w_state_nxt = S_WAIT;
            S_WAIT:  if (commit_valid) w_state_nxt = S_ISSUE;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        pc_valid = (r_state == S_ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc            <= RESET_VECTOR;
            r_issue_cnt     <= '0;
            r_misalign_trap <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign_trap <= w_commit && w_misalign;
            if (w_fire) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
            if (w_commit) begin
                r_pc <= w_next_pc;
                if (w_misalign) begin
                    r_misalign_addr <= w_target;
                end
            end
        end
    end

    assign pc            = r_pc;
    assign misalign_trap = r_misalign_trap;
    assign misalign_addr = r_misalign_addr;
    assign issue_cnt     = r_issue_cnt;

endmodule

// File: doc/pcu_hs.md
Name: pcu_hs

Overview:
- Parametrised program-counter unit; successor to the single-cycle PC register.
- Issues the PC to the IFU over a valid/ready handshake, then waits for the EXU commit of that instruction before computing the next PC.
- Next-PC sources, highest priority first: trap vector, mret, jal/branch, jalr.
- Adds misaligned-target detection (redirect to mtvec) and an issued-PC counter.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_VECTOR, 32'h8000_0000, PC value after reset.
- IALIGN, 32, instruction alignment in bits; 32 or 16 only.
- CNT_W, 32, width of issue counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pc_valid  out  1  pc holds an address for IFU
- pc_ready  in  1  IFU accepts pc
- pc  out  XLEN  current fetch address
- commit_valid  in  1  EXU commits the instruction at pc; the qualifiers below are sampled only when this is 1
- imm  in  XLEN  decoded immediate
- rs1_data  in  XLEN  rs1 value
- jal_en  in  1  jal
- jalr_en  in  1  jalr
- branch_en  in  1  conditional branch
- branch_taken  in  1  branch condition true (from EXU)
- ecall_en  in  1  ecall
- mret_en  in  1  mret
- mtvec  in  XLEN  trap vector (CSR)
- mepc  in  XLEN  return address (CSR)
- misalign_trap  out  1  one-cycle pulse: target misaligned, redirected to mtvec
- misalign_addr  out  XLEN  offending target, held until next trap
- issue_cnt  out  CNT_W  count of completed pc handshakes

Behaviour:
- Reset (async, rst=1): pc=RESET_VECTOR, state=BOOT, pc_valid=0, misalign_trap=0, misalign_addr=0, issue_cnt=0. Applies mid-operation from any state; an in-flight handshake or commit is dropped.
- States:
  - BOOT: pc_valid=0; always advances to ISSUE next cycle. This gives one idle cycle after reset release.
  - ISSUE: pc_valid=1 and pc held stable. On pc_valid&pc_ready: issue_cnt+=1 (wraps at 2^CNT_W), go WAIT. Otherwise stay; valid is never withdrawn.
  - WAIT: pc_valid=0. On commit_valid: pc<=next_pc, go ISSUE. Otherwise stay.
- commit_valid is ignored in BOOT and ISSUE. pc_ready is ignored outside ISSUE.
- Latency: commit to new pc_valid is 1 cycle. Back-to-back best case is one instruction per 2 cycles (ISSUE, WAIT).
- next_pc priority when commit_valid=1:
  1. ecall_en: mtvec & align_mask.
  2. mret_en: mepc & align_mask.
  3. jal_en | (branch_en & branch_taken): target = pc + imm.
  4. jalr_en: target = (rs1_data + imm) & ~1.
  5. Otherwise: pc + (IALIGN==32 ? 4 : 2).
- align_mask clears bits [1:0] for IALIGN=32 and bit [0] for IALIGN=16.
- If ecall_en and mret_en are both set, ecall wins. Multiple jump qualifiers are resolved by the same priority.
- Arithmetic is modulo 2^XLEN; wrap-around at the top of the address space is silent, with no flag.
- Misalignment applies to sources 3 and 4 only. Misaligned means target[1]!=0 for IALIGN=32, or target[0]!=0 for IALIGN=16.
  - If misaligned: next_pc = mtvec & align_mask, misalign_trap=1 for exactly the cycle pc updates, misalign_addr<=target.
  - No redirect or pulse on the sequential path or on ecall/mret.
- branch_en with branch_taken=0 is treated as sequential.
- issue_cnt and pc update only as stated above. No outputs change in WAIT without commit_valid.

Test Plan:
- Reset/boot: assert rst mid-WAIT, then release → pc=0x8000_0000, pc_valid=0 for 1 cycle then 1, issue_cnt=0, misalign_trap=0.
- Sequential + backpressure: hold pc_ready=0 for 3 cycles in ISSUE → pc_valid stays 1 and pc stable at 0x8000_0000. Then ready=1 and commit with no qualifiers → next pc=0x8000_0004, issue_cnt=1.
- Jumps: at pc=0x8000_0010:
  - jal with imm=0xFFFF_FFF0 → 0x8000_0000.
  - branch_en=1, branch_taken=0 with imm=0x40 → 0x8000_0014.
  - jalr with rs1=0x8000_0101, imm=0x3 → 0x8000_0104.
- Trap priority: ecall_en=mret_en=jal_en=1, mtvec=0x8000_0203, mepc=0x8000_0300 → pc=0x8000_0200 and no misalign pulse. Then mret alone → 0x8000_0300.
- Misaligned: IALIGN=32, pc=0x8000_0000, jal imm=0x6 → pc=mtvec&~3, misalign_trap high for 1 cycle, misalign_addr=0x8000_0006. Repeat with IALIGN=16 → pc=0x8000_0006 and no trap.
- Wrap/counter: pc=0xFFFF_FFFC sequential → 0x0000_0000. CNT_W=4, 16 handshakes → issue_cnt=0.
